// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential Booth signed multiplier with a start/done handshake.
//
// Multiplies two WIDTH-bit two's-complement operands and returns the exact 2*WIDTH-bit
// product. This is also exact when an operand is the most-negative value.
// The default build retires one multiplier bit per cycle (radix-2, ITER = WIDTH).
// Defining BOOTH_SEQ_MUL_RADIX4_EN selects modified-Booth radix-4, which retires two bits
// per cycle (ITER = WIDTH/2). Both builds have the same ports and handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, accepted only while idle (busy = 0)
//   m, q   signed multiplicand / multiplier, captured on accept
//   busy   high from the cycle after accept through the done cycle
//   done   one-cycle pulse, p valid in the same cycle
//   p      signed product, held until the next done or reset
module booth_seq_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

`ifdef BOOTH_SEQ_MUL_RADIX4_EN
  localparam int unsigned Ext  = 2;
  localparam int unsigned Iter = WIDTH / 2;
`else
  localparam int unsigned Ext  = 1;
  localparam int unsigned Iter = WIDTH;
`endif
  // Extra accumulator headroom keeps A - M (or A - 2M) from overflowing on -2^(WIDTH-1).
  localparam int unsigned AW   = WIDTH + Ext;
  localparam int unsigned CntW = $clog2(Iter);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      m_q, m_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic               q1_q, q1_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic               accept;
  logic               last_step;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      a_step;
  logic [WIDTH-1:0]   q_step;
  logic               q1_step;

  assign accept    = (state_q == StIdle) && start;
  assign last_step = (cnt_q == CntW'(Iter - 1));

  // One Booth step: add the recoded digit, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    sum = a_q;
`ifdef BOOTH_SEQ_MUL_RADIX4_EN
    unique case ({qr_q[1:0], q1_q})
      3'b001, 3'b010: sum = a_q + m_q;
      3'b011:         sum = a_q + (m_q << 1);
      3'b100:         sum = a_q - (m_q << 1);
      3'b101, 3'b110: sum = a_q - m_q;
      default:        sum = a_q;
    endcase
    a_step  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_step  = {sum[1:0], qr_q[WIDTH-1:2]};
    q1_step = qr_q[1];
`else
    unique case ({qr_q[0], q1_q})
      2'b10:   sum = a_q - m_q;
      2'b01:   sum = a_q + m_q;
      default: sum = a_q;
    endcase
    a_step  = {sum[AW-1], sum[AW-1:1]};
    q_step  = {sum[0], qr_q[WIDTH-1:1]};
    q1_step = qr_q[0];
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    m_d   = m_q;
    a_d   = a_q;
    qr_d  = qr_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    if (accept) begin
      m_d   = {{Ext{m[WIDTH-1]}}, m};
      a_d   = '0;
      qr_d  = q;
      q1_d  = 1'b0;
      cnt_d = '0;
    end else if (state_q == StRun) begin
      a_d   = a_step;
      qr_d  = q_step;
      q1_d  = q1_step;
      cnt_d = cnt_q + 1'b1;
      // Load p on the final step so it is already valid in the done cycle.
      if (last_step) p_d = {a_step[WIDTH-1:0], q_step};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      a_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    p    = p_q;
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
// Scoreboard bench for booth_seq_mul (WIDTH = 16). The driver pushes hand-computed products.
// A monitor pops one product for each done pulse and compares it with p.
module tb_booth_seq_mul;
  localparam int W = 16;
`ifdef BOOTH_SEQ_MUL_RADIX4_EN
  localparam int ITER = W / 2;
`else
  localparam int ITER = W;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m     (m),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int last_lat = 0;
  int hold_err = 0;
  int done_cycs[$];
  logic [2*W-1:0] exp_q[$];
  string          nm_q[$];
  logic           busy_prev = 1'b0;
  logic [2*W-1:0] p_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: runs 2ns after each rising edge, when the DUT outputs have settled.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst_n && busy && !busy_prev) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cycs.push_back(cyc);
      last_lat = cyc - acc_cyc;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done with p=0x%0h, expected no done", p);
      end else begin
        check(nm_q.pop_front(), 64'(p), 64'(exp_q.pop_front()));
      end
    end
    if (rst_n && !done && p !== p_prev) hold_err++;
    p_prev    = p;
    busy_prev = busy;
  end

  task automatic issue(input logic [W-1:0] mm, input logic [W-1:0] qq,
                       input logic [2*W-1:0] e, input string n);
    int k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      total++;
      $display("FAIL %s_idle_wait: busy still 1, expected 0", n);
    end
    start = 1'b1;
    m     = mm;
    q     = qq;
    exp_q.push_back(e);
    nm_q.push_back(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the first falling edge after the target done count is reached.
  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) begin
      total++;
      $display("FAIL done_timeout: got %0d dones, expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    int d0;
    int base;
    logic [W-1:0]   hm[3];
    logic [W-1:0]   hq[3];
    logic [2*W-1:0] hp[3];

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // The done pulse comes ITER edges after the accept edge.
    // Counting the accept edge, that is ITER+1 cycles.
    issue(16'd3, 16'd5, 32'h0000000F, "t1_3x5");
    wait_done(1);
    check("t1_latency", 64'(last_lat), 64'(ITER));
    @(negedge clk);
    check("t1_busy_after_done", 64'(busy), 64'd0);
    check("t1_done_after_done", 64'(done), 64'd0);

    issue(16'h8000, 16'h8000, 32'h40000000, "t2_min_x_min");
    issue(16'h8000, 16'h0001, 32'hFFFF8000, "t2_min_x_1");
    issue(16'h7FFF, 16'h8000, 32'hC0008000, "t2_max_x_min");
    issue(16'hFFFF, 16'hFFFF, 32'h00000001, "x_m1_m1");
    issue(16'h7FFF, 16'h7FFF, 32'h3FFF0001, "x_max_max");
    issue(16'd12345, 16'hFFFE, 32'hFFFF9F8E, "x_12345_m2");
    issue(16'hFFFF, 16'h7FFF, 32'hFFFF8001, "x_m1_max");
    wait_done(8);

    // A start pulse during RUN must be ignored.
    d0 = done_cnt;
    issue(16'hFFF9, 16'd6, 32'hFFFFFFD6, "t3_m7_x_6");
    repeat (4) @(negedge clk);
    start = 1'b1;
    m     = 16'd100;
    q     = 16'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1);
    repeat (30) @(negedge clk);
    check("t3_single_done", 64'(done_cnt), 64'(d0 + 1));

    // Hold start high for three back-to-back operations.
    hm[0] = 16'd2;    hq[0] = 16'd3;    hp[0] = 32'h00000006;
    hm[1] = 16'hFFFC; hq[1] = 16'd5;    hp[1] = 32'hFFFFFFEC;
    hm[2] = 16'd0;    hq[2] = 16'hFFFF; hp[2] = 32'h00000000;
    d0   = done_cnt;
    base = done_cycs.size();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int k = 0;
      while (busy && k < 100) begin
        @(negedge clk);
        k++;
      end
      m = hm[i];
      q = hq[i];
      exp_q.push_back(hp[i]);
      nm_q.push_back($sformatf("t4_held_op%0d", i));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(d0 + 3);
    if (done_cycs.size() >= base + 3) begin
      check("t4_gap_0_1", 64'(done_cycs[base+1] - done_cycs[base]), 64'(ITER + 2));
      check("t4_gap_1_2", 64'(done_cycs[base+2] - done_cycs[base+1]), 64'(ITER + 2));
    end else begin
      total++;
      $display("FAIL t4_done_count: got %0d dones, expected 3", done_cycs.size() - base);
    end

    // Reset in the middle of a RUN aborts the operation.
    d0 = done_cnt;
    issue(16'd9, 16'd9, 32'h00000051, "t5_aborted");
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    nm_q.delete();
    check("t5_p_after_reset", 64'(p), 64'd0);
    check("t5_busy_after_reset", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    check("t5_no_done", 64'(done_cnt), 64'(d0));
    issue(16'd9, 16'hFFF7, 32'hFFFFFFAF, "t5_after_reset");
    wait_done(d0 + 1);
    repeat (3) @(negedge clk);

    check("p_hold_violations", 64'(hold_err), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("done_vs_accept", 64'(done_cnt), 64'(acc_cnt - 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
